// File: rtl/uart_tx_serializer_if.sv
// Read-side handshake of the transmit FIFO as seen by the UART serializer.
// master = FIFO side (drives head entry and not-empty), slave = serializer (drives the pop strobe).
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_not_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_rd_en_o;

    modport master (
        output fifo_not_empty_i,
        output fifo_rd_data_i,
        input  fifo_rd_en_o
    );

    modport slave (
        input  fifo_not_empty_i,
        input  fifo_rd_data_i,
        output fifo_rd_en_o
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO entry per frame and shifts it out LSB first.
// Optional even-parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_tx_serializer_if.slave  fifo,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned      CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                r_state,    w_state_nx;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_nx;
    logic [DIV_WIDTH-1:0]  r_div,      w_div_nx;
    logic [DIV_WIDTH-1:0]  r_baud_cnt, w_baud_cnt_nx;
    logic [CNT_W-1:0]      r_bit_cnt,  w_bit_cnt_nx;
    logic                  r_tx,       w_tx_nx;
    logic                  r_busy,     w_busy_nx;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity,   w_parity_nx;
`endif

    logic w_bit_end;
    logic w_last_stop;
    logic w_pop;

    // Bit period ends when the down-counter hits zero; pops happen only at frame boundaries.
    assign w_bit_end   = (r_baud_cnt == '0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
    assign w_pop       = rst_i && fifo.fifo_not_empty_i && ((r_state == S_IDLE) || w_last_stop);

    assign fifo.fifo_rd_en_o = w_pop;
    assign tx_o              = r_tx;
    assign busy_o            = r_busy;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_div      <= w_div_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_div_nx      = r_div;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_tx_nx       = r_tx;
        w_busy_nx     = r_busy;
`ifdef UART_TX_PARITY_EN
        w_parity_nx   = r_parity;
`endif

        if (!w_bit_end) begin
            w_baud_cnt_nx = r_baud_cnt - DIV_WIDTH'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx    = S_DATA;
                    w_tx_nx       = r_shift[0];
                    w_shift_nx    = r_shift >> 1;
                    w_bit_cnt_nx  = '0;
                    w_baud_cnt_nx = r_div;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nx = r_div;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nx   = S_PARITY;
                        w_tx_nx      = r_parity;
`else
                        w_state_nx   = S_STOP;
                        w_tx_nx      = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + CNT_W'(1);
                        w_tx_nx      = r_shift[0];
                        w_shift_nx   = r_shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx    = S_STOP;
                    w_tx_nx       = 1'b1;
                    w_bit_cnt_nx  = '0;
                    w_baud_cnt_nx = r_div;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_state_nx = S_IDLE;
                        w_tx_nx    = 1'b1;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_bit_cnt_nx  = r_bit_cnt + CNT_W'(1);
                        w_baud_cnt_nx = r_div;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // A pop overrides the frame-end path so the next start bit follows with no gap.
        if (w_pop) begin
            w_state_nx    = S_START;
            w_tx_nx       = 1'b0;
            w_busy_nx     = 1'b1;
            w_shift_nx    = fifo.fifo_rd_data_i;
            w_div_nx      = baud_div_i;
            w_baud_cnt_nx = baud_div_i;
            w_bit_cnt_nx  = '0;
`ifdef UART_TX_PARITY_EN
            w_parity_nx   = ^fifo.fifo_rd_data_i;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: FIFO model, per-cycle line scoreboard,
// a table of single-frame vectors and hand-written multi-frame / reset sequences.
module tb_uart_tx_serializer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DIVW  = 16;
    localparam int unsigned STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int FL = int'(1 + DW + PB + STOPB);

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [10:0] frame;
        int          len;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [DIVW-1:0] baud_div;
    logic            tx;
    logic            busy;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) fifo_if ();

    uart_tx_serializer #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DIVW),
        .STOP_BITS  (STOPB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .fifo       (fifo_if.slave),
        .baud_div_i (baud_div),
        .tx_o       (tx),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         n_pops = 0;
    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    int         pop_times[$];
    vec_t       vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: pop on the edge that ends an rd_en cycle, present the new head after the edge.
    always @(posedge clk) begin
        if (fifo_if.fifo_rd_en_o && fifo_q.size() != 0) fifo_q.delete(0);
        fifo_if.fifo_not_empty_i <= (fifo_q.size() != 0);
        fifo_if.fifo_rd_data_i   <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Scoreboard: expected line value per cycle, queued when a pop is observed.
    always @(negedge clk) begin : monitor
        logic       e;
        logic [7:0] d;
        int         n;
        if (!rst_i) begin
            exp_q.delete();
            check("rst_tx",   int'(tx),                   1);
            check("rst_busy", int'(busy),                 0);
            check("rst_rden", int'(fifo_if.fifo_rd_en_o), 0);
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tx_bit",     int'(tx),   int'(e));
                check("busy_frame", int'(busy), 1);
            end else begin
                check("tx_idle",   int'(tx),   1);
                check("busy_idle", int'(busy), 0);
            end
            if (fifo_if.fifo_rd_en_o) begin
                n_pops++;
                pop_times.push_back(cyc);
                check("pop_not_empty", int'(fifo_if.fifo_not_empty_i), 1);
                d = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
                n = int'(baud_div) + 1;
                repeat (n) exp_q.push_back(1'b0);
                for (int i = 0; i < int'(DW); i++) repeat (n) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
                repeat (n) exp_q.push_back(^d);
`endif
                repeat (int'(STOPB) * n) exp_q.push_back(1'b1);
            end
        end
    end

    // Waits for a frame to start, samples the first cycle of every bit and measures busy length.
    task automatic run_frame(input string name, input int div, input logic [10:0] exp_frame,
                             input int exp_len);
        int          len;
        logic [10:0] got;
        got = '0;
        len = 0;
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        check({name, "_start"}, int'(busy), 1);
        while (busy && len < 4000) begin
            if ((len % (div + 1)) == 0 && (len / (div + 1)) < 11) got[len / (div + 1)] = tx;
            len++;
            @(negedge clk);
        end
        check({name, "_frame"}, int'(got), int'(exp_frame));
        check({name, "_len"},   len,       exp_len);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int p0;
        int seen;
        logic [10:0] f_5a;
        logic [10:0] f_c3;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 16'd3, 11'h54A, 44};
        vecs[1] = '{8'h00, 16'd0, 11'h400, 11};
        vecs[2] = '{8'hFF, 16'd1, 11'h5FE, 22};
        vecs[3] = '{8'h3C, 16'd2, 11'h478, 33};
        vecs[4] = '{8'h07, 16'd0, 11'h60E, 11};
        vecs[5] = '{8'h03, 16'd0, 11'h406, 11};
        f_5a = 11'h4B4;
        f_c3 = 11'h586;
`else
        vecs[0] = '{8'hA5, 16'd3, 11'h34A, 40};
        vecs[1] = '{8'h00, 16'd0, 11'h200, 10};
        vecs[2] = '{8'hFF, 16'd1, 11'h3FE, 20};
        vecs[3] = '{8'h3C, 16'd2, 11'h278, 30};
        vecs[4] = '{8'h07, 16'd0, 11'h20E, 10};
        vecs[5] = '{8'h03, 16'd0, 11'h206, 10};
        f_5a = 11'h2B4;
        f_c3 = 11'h386;
`endif

        // Reset with data already waiting: no pop until release, then pop in the first cycle.
        rst_i    = 1'b1;
        baud_div = 16'd3;
        #1 rst_i = 1'b0;
        fifo_q.push_back(8'h5A);
        repeat (3) @(negedge clk);
        check("reset_tx",   int'(tx),                   1);
        check("reset_busy", int'(busy),                 0);
        check("reset_rden", int'(fifo_if.fifo_rd_en_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        #1 check("pop_on_release", int'(fifo_if.fifo_rd_en_o), 1);
        @(negedge clk);
        run_frame("first_5A", 3, f_5a, FL * 4);

        // Table of isolated frames.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            baud_div = vecs[k].div;
            p0       = n_pops;
            fifo_q.push_back(vecs[k].data);
            run_frame($sformatf("vec%0d", k), int'(vecs[k].div), vecs[k].frame, vecs[k].len);
            check($sformatf("vec%0d_pops", k), n_pops - p0, 1);
        end

        // Empty FIFO: line stays idle, no pop.
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_if.fifo_rd_en_o) seen++;
        end
        check("empty_no_pop", seen,       0);
        check("empty_tx",     int'(tx),   1);
        check("empty_busy",   int'(busy), 0);

        // Back-to-back frames at divisor 1.
        @(negedge clk);
        baud_div = 16'd1;
        pop_times.delete();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        for (int i = 0; i < 400 && !(pop_times.size() == 3 && !busy); i++) @(negedge clk);
        check("b2b_pops", pop_times.size(), 3);
        if (pop_times.size() == 3) begin
            check("b2b_gap01", pop_times[1] - pop_times[0], FL * 2);
            check("b2b_gap12", pop_times[2] - pop_times[1], FL * 2);
            check("b2b_last",  cyc - pop_times[2],          FL * 2 + 1);
        end
        check("b2b_idle_tx", int'(tx), 1);

        // Divisor change mid-frame only affects the next frame.
        @(negedge clk);
        baud_div = 16'd3;
        pop_times.delete();
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        for (int i = 0; i < 40 && pop_times.size() == 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        baud_div = 16'd7;
        for (int i = 0; i < 600 && !(pop_times.size() == 2 && !busy); i++) @(negedge clk);
        check("div_pops", pop_times.size(), 2);
        if (pop_times.size() == 2) begin
            check("div_old_frame", pop_times[1] - pop_times[0], FL * 4);
            check("div_new_frame", cyc - pop_times[1],          FL * 8 + 1);
        end

        // Asynchronous reset during data bit 3 of 0x5A; next entry then sends a full frame.
        @(negedge clk);
        baud_div = 16'd3;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'hC3);
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        repeat (17) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_tx",   int'(tx),                   1);
        check("async_rst_busy", int'(busy),                 0);
        check("async_rst_rden", int'(fifo_if.fifo_rd_en_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        #1 check("rst_release_pop", int'(fifo_if.fifo_rd_en_o), 1);
        run_frame("after_rst_C3", 3, f_c3, FL * 4);
        check("fifo_drained", fifo_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
